// File: rtl/mpc_mul_pkg.sv
// Shared widths and the tag record for the time-shared MPC multiplier.
// TAG_ID_W is sized for the largest supported requester count (8).
package mpc_mul_pkg;

    localparam int MUL_A_W  = 21;
    localparam int MUL_B_W  = 7;
    localparam int MUL_P_W  = 28;
    localparam int MUL_LAT  = 4;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mpc_rr_arb.sv
// Combinational round-robin pick: searches req starting just after ptr.
// The pointer register lives in the caller so it can gate updates on handshakes.
module mpc_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mpc_mul_share_arb.sv
// Shares one external pipelined signed multiplier among NUM_REQ requesters.
// A {valid,id} tag pipe tracks the multiplier so each product returns to its issuer.
module mpc_mul_share_arb
    import mpc_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = MUL_A_W,
    parameter int B_WIDTH = MUL_B_W,
    parameter int P_WIDTH = MUL_P_W,
    parameter int LATENCY = MUL_LAT,
    localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       mul_ce,
    output logic [A_WIDTH-1:0]         mul_a,
    output logic [B_WIDTH-1:0]         mul_b,
    input  logic [P_WIDTH-1:0]         mul_p,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_WIDTH-1:0]         rsp_p,
    output logic                       busy
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_en;
    logic               handshake;
    logic [A_WIDTH-1:0] last_a;
    logic [B_WIDTH-1:0] last_b;
    tag_t               tag_q [LATENCY];

    mpc_rr_arb #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign grant_en  = ce & ~reset;
    assign req_ready = grant_en ? gnt : '0;
    assign handshake = |(req_valid & req_ready);
    assign mul_ce    = ce;

    // Idle cycles replay the last issued operands so the multiplier inputs stay quiet.
    always_comb begin
        mul_a = last_a;
        mul_b = last_b;
        if (handshake) begin
            mul_a = req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
            mul_b = req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
            last_a <= '0;
            last_b <= '0;
        end else if (handshake) begin
            rr_ptr <= gnt_idx;
            last_a <= mul_a;
            last_b <= mul_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (ce) begin
            tag_q[0].valid <= handshake;
            tag_q[0].id    <= TAG_ID_W'(gnt_idx);
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // The last tag stage lines up with mul_p; on ce=0 the pulse drops so it never repeats.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else if (ce) begin
            rsp_valid <= tag_q[LATENCY-1].valid;
            rsp_id    <= ID_W'(tag_q[LATENCY-1].id);
            rsp_p     <= mul_p;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    always_comb begin
        busy = rsp_valid;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

endmodule
